// File: rtl/fractal_frame_ctrl_pkg.sv
// Shared types for the fractal frame controller: state encoding, widths and
// the parameter set held in the staging and active registers.
package fractal_pkg;

    localparam int COORD_W = 32;
    localparam int DIM_W   = 16;
    localparam int FCNT_W  = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    typedef struct packed {
        logic [DIM_W-1:0]   width;
        logic [DIM_W-1:0]   height;
        logic [COORD_W-1:0] cr;
        logic [COORD_W-1:0] ci;
        logic [COORD_W-1:0] dx;
        logic [COORD_W-1:0] dy;
        logic [COORD_W-1:0] x0;
        logic [COORD_W-1:0] y0;
    } frame_params_t;

    // Per-frame animation step; additions wrap modulo 2^COORD_W.
    function automatic frame_params_t apply_step(input frame_params_t p,
                                                 input logic [COORD_W-1:0] cr_step,
                                                 input logic [COORD_W-1:0] ci_step);
        frame_params_t r;
        r    = p;
        r.cr = p.cr + cr_step;
        r.ci = p.ci + ci_step;
        return r;
    endfunction

endpackage

// File: rtl/fractal_frame_ctrl_if.sv
// Register-bank, generator-parameter and pixel-monitor signals of the frame
// controller. The controller uses the slave modport, its environment the master.
interface fractal_frame_ctrl_if;
    import fractal_pkg::*;

    logic               cfg_run;
    logic               cfg_oneshot;
    logic               cfg_commit;
    logic               cfg_err_clr;
    logic [DIM_W-1:0]   cfg_width;
    logic [DIM_W-1:0]   cfg_height;
    logic [COORD_W-1:0] cfg_cr;
    logic [COORD_W-1:0] cfg_ci;
    logic [COORD_W-1:0] cfg_dx;
    logic [COORD_W-1:0] cfg_dy;
    logic [COORD_W-1:0] cfg_x0;
    logic [COORD_W-1:0] cfg_y0;
    logic [COORD_W-1:0] cfg_cr_step;
    logic [COORD_W-1:0] cfg_ci_step;

    logic               gen_resetn;
    logic [DIM_W-1:0]   gen_width;
    logic [DIM_W-1:0]   gen_height;
    logic [COORD_W-1:0] gen_cr;
    logic [COORD_W-1:0] gen_ci;
    logic [COORD_W-1:0] gen_dx;
    logic [COORD_W-1:0] gen_dy;
    logic [COORD_W-1:0] gen_x0;
    logic [COORD_W-1:0] gen_y0;

    logic               pix_valid;
    logic               pix_last;
    logic               pix_user;

    logic               sts_busy;
    logic               sts_pending;
    logic               sts_err;
    logic [FCNT_W-1:0]  sts_frame_cnt;
    logic               irq_frame_done;

    modport slave (
        input  cfg_run, cfg_oneshot, cfg_commit, cfg_err_clr,
        input  cfg_width, cfg_height, cfg_cr, cfg_ci, cfg_dx, cfg_dy, cfg_x0, cfg_y0,
        input  cfg_cr_step, cfg_ci_step,
        input  pix_valid, pix_last, pix_user,
        output gen_resetn, gen_width, gen_height, gen_cr, gen_ci, gen_dx, gen_dy, gen_x0, gen_y0,
        output sts_busy, sts_pending, sts_err, sts_frame_cnt, irq_frame_done
    );

    modport master (
        output cfg_run, cfg_oneshot, cfg_commit, cfg_err_clr,
        output cfg_width, cfg_height, cfg_cr, cfg_ci, cfg_dx, cfg_dy, cfg_x0, cfg_y0,
        output cfg_cr_step, cfg_ci_step,
        output pix_valid, pix_last, pix_user,
        input  gen_resetn, gen_width, gen_height, gen_cr, gen_ci, gen_dx, gen_dy, gen_x0, gen_y0,
        input  sts_busy, sts_pending, sts_err, sts_frame_cnt, irq_frame_done
    );

endinterface

// File: rtl/fractal_frame_ctrl_tracker.sv
// Line counter, frame-boundary detect and pixel-stream protocol checks for the
// frame controller. boundary_o and err_o are same-cycle pulses.
module fractal_frame_tracker
    import fractal_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             run_i,
    input  logic [DIM_W-1:0] height_i,
    input  logic             pix_valid_i,
    input  logic             pix_last_i,
    input  logic             pix_user_i,
    output logic             boundary_o,
    output logic             err_o
);

    logic [DIM_W-1:0] line_cnt_q, line_cnt_d;
    logic             sol_q, sol_d;
    logic             line_end;
    logic             last_line;

    assign line_end   = run_i & pix_valid_i & pix_last_i;
    assign last_line  = (line_cnt_q == (height_i - DIM_W'(1)));
    assign boundary_o = line_end & last_line;

    // frame_start is legal only on the first beat of the first line
    assign err_o = (pix_valid_i & ~run_i)
                 | (run_i & pix_valid_i & pix_user_i & ((line_cnt_q != '0) | ~sol_q));

    always_comb begin
        line_cnt_d = line_cnt_q;
        sol_d      = sol_q;
        if (clr_i) begin
            line_cnt_d = '0;
            sol_d      = 1'b1;
        end else if (run_i && pix_valid_i) begin
            sol_d = pix_last_i;
            if (pix_last_i) begin
                line_cnt_d = last_line ? '0 : line_cnt_q + DIM_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_cnt_q <= '0;
            sol_q      <= 1'b1;
        end else begin
            line_cnt_q <= line_cnt_d;
            sol_q      <= sol_d;
        end
    end

endmodule

// File: rtl/fractal_frame_ctrl.sv
// Frame-boundary parameter controller for fractal_generator. Define
// FRACTAL_ANIM_EN to step cr/ci by cfg_cr_step/cfg_ci_step at every boundary.
module fractal_frame_ctrl
    import fractal_pkg::*;
(
    input  logic                aclk,
    input  logic                aresetn,
    fractal_frame_ctrl_if.slave bus
);

`ifdef FRACTAL_ANIM_EN
    localparam bit ANIM_EN = 1'b1;
`else
    localparam bit ANIM_EN = 1'b0;
`endif

    state_t            state_q;
    frame_params_t     stage_q, stage_d;
    frame_params_t     active_q;
    frame_params_t     cfg_params;
    logic              pending_q, pending_d;
    logic              err_q, err_d;
    logic              gen_resetn_q;
    logic              irq_q;
    logic [FCNT_W-1:0] frame_cnt_q;
    logic              commit_ok, commit_bad;
    logic              boundary, trk_err;
`ifdef FRACTAL_ANIM_EN
    logic              load_stage_q;
`else
    logic              unused_steps;
    assign unused_steps = ^{bus.cfg_cr_step, bus.cfg_ci_step};
`endif

    assign cfg_params = '{width:  bus.cfg_width,  height: bus.cfg_height,
                          cr:     bus.cfg_cr,     ci:     bus.cfg_ci,
                          dx:     bus.cfg_dx,     dy:     bus.cfg_dy,
                          x0:     bus.cfg_x0,     y0:     bus.cfg_y0};

    assign commit_ok  = bus.cfg_commit & (bus.cfg_width != '0) & (bus.cfg_height != '0);
    assign commit_bad = bus.cfg_commit & ((bus.cfg_width == '0) | (bus.cfg_height == '0));

    fractal_frame_tracker u_tracker (
        .clk         (aclk),
        .rst_n       (aresetn),
        .clr_i       (state_q == ST_LOAD),
        .run_i       (state_q == ST_RUN),
        .height_i    (active_q.height),
        .pix_valid_i (bus.pix_valid),
        .pix_last_i  (bus.pix_last),
        .pix_user_i  (bus.pix_user),
        .boundary_o  (boundary),
        .err_o       (trk_err)
    );

    // A commit in the LOAD cycle re-arms pending for the next boundary.
    always_comb begin
        stage_d   = stage_q;
        pending_d = pending_q;
        if (state_q == ST_LOAD) begin
            pending_d = 1'b0;
        end
        if (commit_ok) begin
            stage_d   = cfg_params;
            pending_d = 1'b1;
        end
        err_d = (err_q & ~bus.cfg_err_clr) | commit_bad | trk_err;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            stage_q   <= '0;
            pending_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            stage_q   <= stage_d;
            pending_q <= pending_d;
            err_q     <= err_d;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= ST_IDLE;
            active_q     <= '0;
            gen_resetn_q <= 1'b0;
            irq_q        <= 1'b0;
            frame_cnt_q  <= '0;
`ifdef FRACTAL_ANIM_EN
            load_stage_q <= 1'b0;
`endif
        end else begin
            irq_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    gen_resetn_q <= 1'b0;
                    if (bus.cfg_run && pending_q) begin
                        state_q <= ST_LOAD;
`ifdef FRACTAL_ANIM_EN
                        load_stage_q <= 1'b1;
`endif
                    end
                end
                ST_LOAD: begin
`ifdef FRACTAL_ANIM_EN
                    active_q <= load_stage_q ? stage_q
                                             : apply_step(active_q, bus.cfg_cr_step, bus.cfg_ci_step);
`else
                    active_q <= stage_q;
`endif
                    gen_resetn_q <= 1'b1;
                    state_q      <= ST_RUN;
                end
                ST_RUN: begin
                    if (boundary) begin
                        irq_q       <= 1'b1;
                        frame_cnt_q <= frame_cnt_q + FCNT_W'(1);
                        if (!bus.cfg_run || bus.cfg_oneshot) begin
                            state_q      <= ST_IDLE;
                            gen_resetn_q <= 1'b0;
                        end else if (pending_q || ANIM_EN) begin
                            state_q      <= ST_LOAD;
                            gen_resetn_q <= 1'b0;
`ifdef FRACTAL_ANIM_EN
                            load_stage_q <= pending_q;
`endif
                        end
                    end
                end
                default: begin
                    state_q      <= ST_IDLE;
                    gen_resetn_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gen_resetn     = gen_resetn_q;
    assign bus.gen_width      = active_q.width;
    assign bus.gen_height     = active_q.height;
    assign bus.gen_cr         = active_q.cr;
    assign bus.gen_ci         = active_q.ci;
    assign bus.gen_dx         = active_q.dx;
    assign bus.gen_dy         = active_q.dy;
    assign bus.gen_x0         = active_q.x0;
    assign bus.gen_y0         = active_q.y0;
    assign bus.sts_busy       = (state_q != ST_IDLE);
    assign bus.sts_pending    = pending_q;
    assign bus.sts_err        = err_q;
    assign bus.sts_frame_cnt  = frame_cnt_q;
    assign bus.irq_frame_done = irq_q;

endmodule

// File: tb/tb_fractal_frame_ctrl.sv
// Directed bench for fractal_frame_ctrl: parameter load timing, frame
// boundaries, commit/error handling, oneshot stop and asynchronous reset.
module tb_fractal_frame_ctrl;
    import fractal_pkg::*;

`ifdef FRACTAL_ANIM_EN
    localparam bit ANIM = 1'b1;
`else
    localparam bit ANIM = 1'b0;
`endif

    logic aclk    = 1'b0;
    logic aresetn = 1'b0;
    int   total   = 0;
    int   bad     = 0;
    int   irq_seen;

    fractal_frame_ctrl_if bus_if ();

    fractal_frame_ctrl dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .bus     (bus_if)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic commit();
        bus_if.cfg_commit = 1'b1;
        tick();
        bus_if.cfg_commit = 1'b0;
    endtask

    task automatic err_clear();
        bus_if.cfg_err_clr = 1'b1;
        tick();
        bus_if.cfg_err_clr = 1'b0;
    endtask

    // n consecutive line-end beats; counts irq pulses seen after each edge
    task automatic beats(input int n);
        bus_if.pix_valid = 1'b1;
        bus_if.pix_last  = 1'b1;
        irq_seen = 0;
        repeat (n) begin
            tick();
            irq_seen += int'(bus_if.irq_frame_done);
        end
        bus_if.pix_valid = 1'b0;
        bus_if.pix_last  = 1'b0;
        bus_if.pix_user  = 1'b0;
    endtask

    initial begin
        bus_if.cfg_run     = 1'b0;
        bus_if.cfg_oneshot = 1'b0;
        bus_if.cfg_commit  = 1'b0;
        bus_if.cfg_err_clr = 1'b0;
        bus_if.cfg_width   = '0;
        bus_if.cfg_height  = '0;
        bus_if.cfg_cr      = '0;
        bus_if.cfg_ci      = '0;
        bus_if.cfg_dx      = '0;
        bus_if.cfg_dy      = '0;
        bus_if.cfg_x0      = '0;
        bus_if.cfg_y0      = '0;
        bus_if.cfg_cr_step = '0;
        bus_if.cfg_ci_step = '0;
        bus_if.pix_valid   = 1'b0;
        bus_if.pix_last    = 1'b0;
        bus_if.pix_user    = 1'b0;

        tick();
        tick();
        chk("rst_gen_resetn", bus_if.gen_resetn, 0);
        chk("rst_busy", bus_if.sts_busy, 0);
        chk("rst_pending", bus_if.sts_pending, 0);
        chk("rst_err", bus_if.sts_err, 0);
        chk("rst_frame_cnt", bus_if.sts_frame_cnt, 0);
        chk("rst_irq", bus_if.irq_frame_done, 0);
        chk("rst_gen_width", bus_if.gen_width, 0);
        aresetn = 1'b1;
        tick();

        // commit 1920x1080 and start
        bus_if.cfg_width  = 16'd1920;
        bus_if.cfg_height = 16'd1080;
        bus_if.cfg_cr     = 32'h1111_1111;
        bus_if.cfg_ci     = 32'h2222_0000;
        bus_if.cfg_dx     = 32'h0000_0100;
        bus_if.cfg_dy     = 32'h0000_0200;
        bus_if.cfg_x0     = 32'hFFFF_0000;
        bus_if.cfg_y0     = 32'h0001_0000;
        commit();
        chk("commit_pending", bus_if.sts_pending, 1);
        chk("commit_busy", bus_if.sts_busy, 0);
        chk("commit_gen_width_held", bus_if.gen_width, 0);
        bus_if.cfg_run = 1'b1;
        tick();
        chk("load_busy", bus_if.sts_busy, 1);
        chk("load_gen_resetn", bus_if.gen_resetn, 0);
        chk("load_gen_width_held", bus_if.gen_width, 0);
        tick();
        chk("run_gen_resetn", bus_if.gen_resetn, 1);
        chk("run_gen_width", bus_if.gen_width, 1920);
        chk("run_gen_height", bus_if.gen_height, 1080);
        chk("run_gen_cr", bus_if.gen_cr, 32'h1111_1111);
        chk("run_gen_ci", bus_if.gen_ci, 32'h2222_0000);
        chk("run_gen_dy", bus_if.gen_dy, 32'h0000_0200);
        chk("run_gen_x0", bus_if.gen_x0, 32'hFFFF_0000);
        chk("run_pending", bus_if.sts_pending, 0);

        // frame 1: first beat carries frame_start, 1080 line ends in total
        bus_if.pix_valid = 1'b1;
        bus_if.pix_last  = 1'b1;
        bus_if.pix_user  = 1'b1;
        tick();
        bus_if.pix_user  = 1'b0;
        beats(1078);
        chk("f1_no_early_irq", irq_seen, 0);
        bus_if.pix_valid = 1'b1;
        bus_if.pix_last  = 1'b1;
        tick();
        bus_if.pix_valid = 1'b0;
        bus_if.pix_last  = 1'b0;
        chk("f1_irq", bus_if.irq_frame_done, 1);
        chk("f1_frame_cnt", bus_if.sts_frame_cnt, 1);
        chk("f1_gen_resetn", bus_if.gen_resetn, ANIM ? 0 : 1);
        tick();
        chk("f1_irq_pulse_end", bus_if.irq_frame_done, 0);
        chk("f1_gen_resetn_after", bus_if.gen_resetn, 1);
        chk("f1_err_clean", bus_if.sts_err, 0);
        chk("f1_gen_cr", bus_if.gen_cr, 32'h1111_1111);

        // frame 2: commit new cr mid-frame, applies at the boundary
        beats(500);
        bus_if.cfg_cr = 32'h3333_3333;
        commit();
        chk("f2_cr_held", bus_if.gen_cr, 32'h1111_1111);
        chk("f2_pending", bus_if.sts_pending, 1);
        beats(579);
        chk("f2_no_early_irq", irq_seen, 0);
        chk("f2_rstn_high", bus_if.gen_resetn, 1);
        bus_if.pix_valid = 1'b1;
        bus_if.pix_last  = 1'b1;
        tick();
        bus_if.pix_valid = 1'b0;
        bus_if.pix_last  = 1'b0;
        chk("f2_irq", bus_if.irq_frame_done, 1);
        chk("f2_frame_cnt", bus_if.sts_frame_cnt, 2);
        chk("f2_load_rstn", bus_if.gen_resetn, 0);
        chk("f2_load_cr_old", bus_if.gen_cr, 32'h1111_1111);
        tick();
        chk("f2_run_rstn", bus_if.gen_resetn, 1);
        chk("f2_new_cr", bus_if.gen_cr, 32'h3333_3333);
        chk("f2_pending_clr", bus_if.sts_pending, 0);

        // invalid commits and error clearing
        bus_if.cfg_height = 16'd0;
        commit();
        chk("bad_commit_err", bus_if.sts_err, 1);
        chk("bad_commit_pending", bus_if.sts_pending, 0);
        bus_if.cfg_commit  = 1'b1;
        bus_if.cfg_err_clr = 1'b1;
        tick();
        bus_if.cfg_commit  = 1'b0;
        bus_if.cfg_err_clr = 1'b0;
        chk("set_wins_err", bus_if.sts_err, 1);
        err_clear();
        chk("err_clr", bus_if.sts_err, 0);
        bus_if.cfg_height = 16'd1080;
        commit();
        bus_if.cfg_height = 16'd0;
        commit();
        chk("bad_commit_err2", bus_if.sts_err, 1);
        chk("bad_commit_keeps_pending", bus_if.sts_pending, 1);
        err_clear();
        chk("err_clr2", bus_if.sts_err, 0);

        // frame_start on line 1 is a protocol error
        beats(1);
        bus_if.pix_valid = 1'b1;
        bus_if.pix_user  = 1'b1;
        tick();
        bus_if.pix_valid = 1'b0;
        bus_if.pix_user  = 1'b0;
        chk("user_mid_frame_err", bus_if.sts_err, 1);
        err_clear();

        // oneshot: frame finishes (line count already at 1), then IDLE
        bus_if.cfg_oneshot = 1'b1;
        beats(1078);
        chk("os_no_early_irq", irq_seen, 0);
        chk("os_cnt_held", bus_if.sts_frame_cnt, 2);
        bus_if.pix_valid = 1'b1;
        bus_if.pix_last  = 1'b1;
        tick();
        bus_if.pix_valid = 1'b0;
        bus_if.pix_last  = 1'b0;
        bus_if.cfg_run   = 1'b0;
        chk("os_irq", bus_if.irq_frame_done, 1);
        chk("os_frame_cnt", bus_if.sts_frame_cnt, 3);
        chk("os_gen_resetn", bus_if.gen_resetn, 0);
        tick();
        chk("os_idle", bus_if.sts_busy, 0);
        chk("os_idle_rstn", bus_if.gen_resetn, 0);

        // pixel traffic while idle is an error
        bus_if.pix_valid = 1'b1;
        tick();
        bus_if.pix_valid = 1'b0;
        chk("idle_valid_err", bus_if.sts_err, 1);

        // small frame, then reset mid-frame
        bus_if.cfg_oneshot = 1'b0;
        bus_if.cfg_width   = 16'd4;
        bus_if.cfg_height  = 16'd2;
        bus_if.cfg_cr      = 32'h0BAD_0000;
        commit();
        bus_if.cfg_run = 1'b1;
        tick();
        tick();
        chk("small_rstn", bus_if.gen_resetn, 1);
        chk("small_height", bus_if.gen_height, 2);
        chk("small_width", bus_if.gen_width, 4);
        beats(1);
        chk("small_no_irq", irq_seen, 0);
        aresetn = 1'b0;
        #1;
        chk("arst_gen_resetn", bus_if.gen_resetn, 0);
        chk("arst_busy", bus_if.sts_busy, 0);
        chk("arst_err", bus_if.sts_err, 0);
        chk("arst_frame_cnt", bus_if.sts_frame_cnt, 0);
        chk("arst_gen_height", bus_if.gen_height, 0);
        chk("arst_gen_cr", bus_if.gen_cr, 0);
        tick();
        aresetn = 1'b1;
        tick();
        chk("arst_stays_idle", bus_if.sts_busy, 0);
        chk("arst_pending", bus_if.sts_pending, 0);

`ifdef FRACTAL_ANIM_EN
        // animation step wraps cr at the 32-bit boundary
        bus_if.cfg_width   = 16'd4;
        bus_if.cfg_height  = 16'd1;
        bus_if.cfg_cr      = 32'h7FFF_FFFF;
        bus_if.cfg_ci      = 32'h0000_0000;
        bus_if.cfg_cr_step = 32'h0000_0001;
        bus_if.cfg_ci_step = 32'hFFFF_FFFF;
        commit();
        tick();
        tick();
        chk("anim_cr_start", bus_if.gen_cr, 32'h7FFF_FFFF);
        bus_if.pix_valid = 1'b1;
        bus_if.pix_last  = 1'b1;
        tick();
        bus_if.pix_valid = 1'b0;
        bus_if.pix_last  = 1'b0;
        chk("anim_irq", bus_if.irq_frame_done, 1);
        chk("anim_load_rstn", bus_if.gen_resetn, 0);
        tick();
        chk("anim_cr_wrap", bus_if.gen_cr, 32'h8000_0000);
        chk("anim_ci_wrap", bus_if.gen_ci, 32'hFFFF_FFFF);
        chk("anim_rstn", bus_if.gen_resetn, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
